// File: rtl/csa_pipe_pkg.sv
// Shared sizing helpers for the pipelined carry-select adder.
package csa_pipe_pkg;

  function automatic int unsigned nseg(input int unsigned width, input int unsigned blk);
    return width / blk;
  endfunction

  function automatic int unsigned nstg(input int unsigned width, input int unsigned blk,
                                       input int unsigned sps);
    return width / (blk * sps);
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned blk,
                                   input int unsigned sps);
    return (blk > 0) && (sps > 0) && (width >= blk) && (width % blk == 0) &&
           ((width / blk) % sps == 0);
  endfunction

  // Per-stage payload: a, b, partial sum, carry, carry-into-MSB.
  function automatic int unsigned payload_w(input int unsigned width);
    return 3 * width + 2;
  endfunction

endpackage

// File: rtl/csa_segment.sv
// BLK-bit carry-select segment: both carry hypotheses evaluated, real carry picks one.
module csa_segment #(
  parameter int unsigned BLK = 16
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  logic [BLK:0] sum0;
  logic [BLK:0] sum1;

  always_comb begin
    sum0        = {1'b0, a} + {1'b0, b};
    sum1        = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
    {cout, s}   = cin ? sum1 : sum0;
    c_msb       = a[BLK-1] ^ b[BLK-1] ^ s[BLK-1];
  end

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshakes on both sides.
module csa_pipe_adder
  import csa_pipe_pkg::*;
#(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned BLK          = 16,
  parameter int unsigned SEGS_PER_STG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NSTG = nstg(WIDTH, BLK, SEGS_PER_STG);
  localparam int unsigned SW   = BLK * SEGS_PER_STG;

  if (!params_ok(WIDTH, BLK, SEGS_PER_STG)) begin : g_param_check
    $error("csa_pipe_adder: WIDTH must be a multiple of BLK*SEGS_PER_STG");
  end

  logic [NSTG-1:0]  stg_valid;
  logic [NSTG-1:0]  stg_carry;
  logic [NSTG-1:0]  stg_cmsb;
  logic [NSTG-1:0]  load;
  logic [WIDTH-1:0] stg_a [NSTG];
  logic [WIDTH-1:0] stg_b [NSTG];
  logic [WIDTH-1:0] stg_s [NSTG];

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [WIDTH-1:0]        a_src, b_src, s_src;
    logic                    v_src, c_src;
    logic [SEGS_PER_STG:0]   cc;
    logic [SEGS_PER_STG-1:0] cm;
    logic [SW-1:0]           seg_s;
    logic [WIDTH-1:0]        a_d, a_q, b_d, b_q, s_d, s_q;
    logic                    v_d, v_q, c_d, c_q, m_d, m_q;

    // b is inverted once on entry, so later stages never need sub.
    if (k == 0) begin : g_head
      assign a_src = a;
      assign b_src = sub ? ~b : b;
      assign s_src = '0;
      assign v_src = in_valid;
      assign c_src = c_in;
    end else begin : g_body
      assign a_src = stg_a[k-1];
      assign b_src = stg_b[k-1];
      assign s_src = stg_s[k-1];
      assign v_src = stg_valid[k-1];
      assign c_src = stg_carry[k-1];
    end

    // A stage may load when empty or when its occupant moves on this edge.
    if (k == NSTG - 1) begin : g_tail_ld
      assign load[k] = !v_q | out_ready;
    end else begin : g_mid_ld
      assign load[k] = !v_q | load[k+1];
    end

    assign cc[0] = c_src;
    for (genvar j = 0; j < SEGS_PER_STG; j++) begin : g_seg
      csa_segment #(.BLK(BLK)) u_seg (
        .a     (a_src[k*SW + j*BLK +: BLK]),
        .b     (b_src[k*SW + j*BLK +: BLK]),
        .cin   (cc[j]),
        .s     (seg_s[j*BLK +: BLK]),
        .cout  (cc[j+1]),
        .c_msb (cm[j])
      );
    end

    always_comb begin
      v_d = v_q;
      a_d = a_q;
      b_d = b_q;
      s_d = s_q;
      c_d = c_q;
      m_d = m_q;
      if (load[k]) begin
        v_d = v_src;
      end
      if (load[k] && v_src) begin
        a_d               = a_src;
        b_d               = b_src;
        s_d               = s_src;
        s_d[k*SW +: SW]   = seg_s;
        c_d               = cc[SEGS_PER_STG];
        m_d               = cm[SEGS_PER_STG-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        m_q <= 1'b0;
      end else begin
        v_q <= v_d;
        a_q <= a_d;
        b_q <= b_d;
        s_q <= s_d;
        c_q <= c_d;
        m_q <= m_d;
      end
    end

    assign stg_valid[k] = v_q;
    assign stg_carry[k] = c_q;
    assign stg_cmsb[k]  = m_q;
    assign stg_a[k]     = a_q;
    assign stg_b[k]     = b_q;
    assign stg_s[k]     = s_q;
  end

  assign in_ready  = load[0];
  assign out_valid = stg_valid[NSTG-1];
  assign s         = stg_s[NSTG-1];
  assign c_out     = stg_carry[NSTG-1];
  assign ovf       = stg_cmsb[NSTG-1] ^ stg_carry[NSTG-1];

endmodule
